// File: rtl/axi_block_copy_pkg.sv
// Shared definitions for the AXI block-copy DMA engine and its helpers.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encodings, 4 KB page size in words, and a helper that
// returns how many words remain before the next 4 KB page boundary.
package axi_block_copy_pkg;

  localparam logic [2:0] STATE_IDLE       = 3'd0;
  localparam logic [2:0] STATE_READ_ADDR  = 3'd1;
  localparam logic [2:0] STATE_READ_DATA  = 3'd2;
  localparam logic [2:0] STATE_WRITE_ADDR = 3'd3;
  localparam logic [2:0] STATE_WRITE_DATA = 3'd4;
  localparam logic [2:0] STATE_WRITE_RESP = 3'd5;
  localparam logic [2:0] STATE_DONE       = 3'd6;

  // AXI bursts must not cross a 4 KB page: 1024 32-bit words.
  localparam int AXI_4K_WORDS = 1024;

  // Words left in the page given the word offset within the page (addr[11:2]).
  // Result is 1..1024, hence 11 bits.
  function automatic logic [10:0] words_to_4k(input logic [9:0] word_ofs);
    return 11'(AXI_4K_WORDS) - {1'b0, word_ofs};
  endfunction

endpackage

// File: rtl/axi_copy_chunk_calc.sv
// Chunk size for one DMA burst: min(remaining, BURST_LEN, src page room, dst page room).
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports:
//   i_remaining     words still to copy (must be >= 1 when the result is used)
//   i_src_word_ofs  source address bits [11:2]
//   i_dst_word_ofs  destination address bits [11:2]
//   o_chunk         beats for the next burst, 1..BURST_LEN
module axi_copy_chunk_calc
  import axi_block_copy_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int CHUNK_W     = $clog2(BURST_LEN) + 1
) (
  input  logic [COUNT_WIDTH-1:0] i_remaining,
  input  logic [9:0]             i_src_word_ofs,
  input  logic [9:0]             i_dst_word_ofs,
  output logic [CHUNK_W-1:0]     o_chunk
);

  logic [31:0] w_rem;
  logic [31:0] w_src_room;
  logic [31:0] w_dst_room;
  logic [31:0] w_min;

  assign w_rem      = 32'(i_remaining);
  assign w_src_room = 32'(words_to_4k(i_src_word_ofs));
  assign w_dst_room = 32'(words_to_4k(i_dst_word_ofs));

  always_comb begin
    w_min = 32'(BURST_LEN);
    if (w_rem < w_min)      w_min = w_rem;
    if (w_src_room < w_min) w_min = w_src_room;
    if (w_dst_room < w_min) w_min = w_dst_room;
  end

  // w_min <= BURST_LEN here, so it always fits in CHUNK_W bits.
  assign o_chunk = CHUNK_W'(w_min);

endmodule

// File: rtl/axi_block_copy.sv
// AXI master DMA: copies word_count 32-bit words src->dst as read burst then write burst per chunk.
// Latency: arvalid 1 cycle after start; done pulses 1 cycle after the final B response (2 cycles after start for count 0).
// Backpressure: every channel waits on its ready/valid; valids are pure state decodes and hold address/data until accepted.
// Ports:
//   i_clk, i_reset                clock, asynchronous active-high reset
//   i_start, i_src_addr,
//   i_dst_addr, i_word_count      copy request (sampled only when idle)
//   o_busy, o_done                status
//   o_ar*/i_arready, i_r*/o_rready  AXI read address / read data channels
//   o_aw*/i_awready, o_w*/i_wready  AXI write address / write data channels
//   i_bvalid/o_bready             AXI write response channel
module axi_block_copy
  import axi_block_copy_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [31:0]            i_src_addr,
  input  logic [31:0]            i_dst_addr,
  input  logic [COUNT_WIDTH-1:0] i_word_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [31:0]            o_araddr,
  output logic [7:0]             o_arlen,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  input  logic                   i_rvalid,
  input  logic [31:0]            i_rdata,
  output logic                   o_rready,
  output logic [31:0]            o_awaddr,
  output logic [7:0]             o_awlen,
  output logic                   o_awvalid,
  input  logic                   i_awready,
  output logic [31:0]            o_wdata,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  input  logic                   i_bvalid,
  output logic                   o_bready
);

  localparam int CHUNK_W = $clog2(BURST_LEN) + 1;
  localparam int IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [2:0]             r_state;
  logic [31:0]            r_src;
  logic [31:0]            r_dst;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [CHUNK_W-1:0]     r_beat;
  logic                   r_done;
  logic [31:0]            r_buf [BURST_LEN];

  logic [CHUNK_W-1:0]     w_chunk;
  logic [CHUNK_W-1:0]     w_chunk_m1;
  logic                   w_last_beat;
  logic [IDX_W-1:0]       w_idx;

  // r_src/r_dst/r_remaining only change on the B handshake, so the chunk
  // derived from them is stable for the whole read-then-write of one chunk.
  axi_copy_chunk_calc #(
    .BURST_LEN  (BURST_LEN),
    .COUNT_WIDTH(COUNT_WIDTH),
    .CHUNK_W    (CHUNK_W)
  ) u_chunk_calc (
    .i_remaining   (r_remaining),
    .i_src_word_ofs(r_src[11:2]),
    .i_dst_word_ofs(r_dst[11:2]),
    .o_chunk       (w_chunk)
  );

  assign w_chunk_m1  = w_chunk - CHUNK_W'(1);
  assign w_last_beat = (r_beat == w_chunk_m1);
  assign w_idx       = r_beat[IDX_W-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= STATE_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_beat      <= '0;
      r_done      <= 1'b0;
    end else begin
      // done is registered off the DONE state so the pulse lands one cycle
      // after DONE, giving the 2-cycle start-to-done for an empty copy.
      r_done <= (r_state == STATE_DONE);
      case (r_state)
        STATE_IDLE: begin
          if (i_start) begin
            // Low address bits are meaningless for word copies; clear them once.
            r_src       <= i_src_addr & 32'hFFFF_FFFC;
            r_dst       <= i_dst_addr & 32'hFFFF_FFFC;
            r_remaining <= i_word_count;
            r_state     <= (i_word_count == '0) ? STATE_DONE : STATE_READ_ADDR;
          end
        end
        STATE_READ_ADDR: begin
          if (i_arready) begin
            r_beat  <= '0;
            r_state <= STATE_READ_DATA;
          end
        end
        STATE_READ_DATA: begin
          if (i_rvalid) begin
            r_beat <= r_beat + CHUNK_W'(1);
            if (w_last_beat) r_state <= STATE_WRITE_ADDR;
          end
        end
        STATE_WRITE_ADDR: begin
          if (i_awready) begin
            r_beat  <= '0;
            r_state <= STATE_WRITE_DATA;
          end
        end
        STATE_WRITE_DATA: begin
          if (i_wready) begin
            r_beat <= r_beat + CHUNK_W'(1);
            if (w_last_beat) r_state <= STATE_WRITE_RESP;
          end
        end
        STATE_WRITE_RESP: begin
          if (i_bvalid) begin
            r_src       <= r_src + (32'(w_chunk) << 2);
            r_dst       <= r_dst + (32'(w_chunk) << 2);
            r_remaining <= r_remaining - COUNT_WIDTH'(w_chunk);
            r_state     <= (r_remaining == COUNT_WIDTH'(w_chunk)) ? STATE_DONE
                                                                  : STATE_READ_ADDR;
          end
        end
        STATE_DONE: r_state <= STATE_IDLE;
        default:    r_state <= STATE_IDLE;
      endcase
    end
  end

  // Staging buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (r_state == STATE_READ_DATA && i_rvalid) begin
      r_buf[w_idx] <= i_rdata;
    end
  end

  assign o_busy    = (r_state != STATE_IDLE);
  assign o_done    = r_done;

  assign o_araddr  = r_src;
  assign o_arlen   = 8'(w_chunk_m1);
  assign o_arvalid = (r_state == STATE_READ_ADDR);
  assign o_rready  = (r_state == STATE_READ_DATA);

  assign o_awaddr  = r_dst;
  assign o_awlen   = 8'(w_chunk_m1);
  assign o_awvalid = (r_state == STATE_WRITE_ADDR);
  // wvalid is a WRITE_DATA decode, so it can never precede the AW handshake.
  assign o_wvalid  = (r_state == STATE_WRITE_DATA);
  assign o_wdata   = r_buf[w_idx];
  assign o_bready  = (r_state == STATE_WRITE_RESP);

endmodule

// File: tb/tb_axi_block_copy.sv
module tb_axi_block_copy;

  localparam int BL = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   src_addr, dst_addr;
  logic [CW-1:0] word_count;
  logic          busy, done;
  logic [31:0]   araddr, awaddr, wdata, rdata;
  logic [7:0]    arlen, awlen;
  logic          arvalid, arready, rvalid, rready;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_block_copy #(.BURST_LEN(BL), .COUNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_word_count(word_count),
    .o_busy(busy), .o_done(done),
    .o_araddr(araddr), .o_arlen(arlen), .o_arvalid(arvalid), .i_arready(arready),
    .i_rvalid(rvalid), .i_rdata(rdata), .o_rready(rready),
    .o_awaddr(awaddr), .o_awlen(awlen), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wvalid(wvalid), .i_wready(wready),
    .i_bvalid(bvalid), .o_bready(bready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // 64 KB word memory seen by the slave, plus the expected image after a copy.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [39:0] ar_log[$], aw_log[$], exp_ar[$], exp_aw[$];
  logic [31:0] last_dst;
  int          last_cnt;

  bit          bp = 1'b0;
  int          done_cnt = 0;
  bit          any_valid = 1'b0;
  int          w_beats = 0;

  // slave state
  logic [31:0] rd_addr, wr_addr;
  int          rd_left, wr_left;
  bit          b_pend, ar_stall, aw_stall, w_stall;
  logic [39:0] ar_hold, aw_hold;
  logic [31:0] w_hold;

  function automatic int unsigned widx(input logic [31:0] a);
    return 32'(a[15:2]);
  endfunction

  // ---------------- AXI slave model (drives at negedge) ----------------
  initial begin : slave
    arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
    rd_left = 0; wr_left = 0; b_pend = 0; ar_stall = 0; aw_stall = 0; w_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rd_left = 0; wr_left = 0; b_pend = 0; ar_stall = 0; aw_stall = 0; w_stall = 0;
        continue;
      end
      // R channel (bursts accepted at earlier negedges only)
      rvalid = 1'b0;
      rdata  = $urandom;
      if (rready && rd_left > 0) begin
        rvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rvalid) begin
          rdata   = mem[widx(rd_addr)];
          rd_addr = rd_addr + 32'd4;
          rd_left--;
        end
      end
      // AR channel
      if (ar_stall) begin
        n_cmp++;
        if (arvalid !== 1'b1 || {arlen, araddr} !== ar_hold) begin
          n_fail++;
          $display("FAIL ar_stable: got valid=%b len/addr=%h required 1/%h", arvalid, {arlen, araddr}, ar_hold);
        end
      end
      ar_stall = 0;
      arready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arvalid) begin
        if (arready) begin
          ar_log.push_back({arlen, araddr});
          rd_addr = araddr;
          rd_left = int'(arlen) + 1;
        end else begin
          ar_stall = 1;
          ar_hold  = {arlen, araddr};
        end
      end
      // W channel (checked before AW so wr_left only reflects earlier handshakes)
      if (w_stall) begin
        n_cmp++;
        if (wvalid !== 1'b1 || wdata !== w_hold) begin
          n_fail++;
          $display("FAIL w_stable: got valid=%b data=%h required 1/%h", wvalid, wdata, w_hold);
        end
      end
      w_stall = 0;
      wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid) begin
        n_cmp++;
        if (awvalid === 1'b1 || wr_left == 0) begin
          n_fail++;
          $display("FAIL w_before_aw: got wvalid=1 awvalid=%b beats_open=%0d required beats_open>0", awvalid, wr_left);
        end
        if (wready) begin
          if (wr_left > 0) begin
            mem[widx(wr_addr)] = wdata;
            wr_addr = wr_addr + 32'd4;
            wr_left--;
            if (wr_left == 0) b_pend = 1;
          end
          w_beats++;
        end else begin
          w_stall = 1;
          w_hold  = wdata;
        end
      end
      // AW channel
      if (aw_stall) begin
        n_cmp++;
        if (awvalid !== 1'b1 || {awlen, awaddr} !== aw_hold) begin
          n_fail++;
          $display("FAIL aw_stable: got valid=%b len/addr=%h required 1/%h", awvalid, {awlen, awaddr}, aw_hold);
        end
      end
      aw_stall = 0;
      awready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (awvalid) begin
        if (awready) begin
          aw_log.push_back({awlen, awaddr});
          wr_addr = awaddr;
          wr_left = int'(awlen) + 1;
        end else begin
          aw_stall = 1;
          aw_hold  = {awlen, awaddr};
        end
      end
      // B channel
      bvalid = 1'b0;
      if (bready && b_pend) begin
        bvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bvalid) b_pend = 0;
      end
    end
  end

  // done / activity monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (arvalid | awvalid | wvalid | rready | bready) any_valid = 1'b1;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input logic [31:0] src, input logic [31:0] dst, input int cnt);
    logic [31:0] s, d;
    int rem, c, room;
    @(negedge clk);
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    s = src & 32'hFFFF_FFFC;
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < cnt; i++)
      ref_mem[widx(d + 32'(4 * i))] = mem[widx(s + 32'(4 * i))];
    exp_ar.delete(); exp_aw.delete(); ar_log.delete(); aw_log.delete();
    last_dst = d; last_cnt = cnt;
    rem = cnt;
    while (rem > 0) begin
      c = rem;
      if (c > BL) c = BL;
      room = (4096 - int'(s & 32'hFFF)) / 4;
      if (c > room) c = room;
      room = (4096 - int'(d & 32'hFFF)) / 4;
      if (c > room) c = room;
      exp_ar.push_back({8'(c - 1), s});
      exp_aw.push_back({8'(c - 1), d});
      s = s + 32'(4 * c);
      d = d + 32'(4 * c);
      rem = rem - c;
    end
    done_cnt = 0; any_valid = 0; w_beats = 0;
    src_addr = src; dst_addr = dst; word_count = CW'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start: got %b required 1", busy);
    end
    n_cmp++;
    if (arvalid !== (cnt != 0)) begin
      n_fail++; $display("FAIL arvalid_after_start: got %b required %b", arvalid, (cnt != 0));
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_early: got %b required 0", done);
    end
  endtask

  task automatic finish_copy(input string name);
    int bad;
    int first_bad;
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(negedge clk);
    n_cmp++;
    if (done_cnt == 0) begin
      n_fail++; $display("FAIL %s done_timeout: got no done required one pulse", name);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
    end
    n_cmp++;
    if (ar_log.size() != exp_ar.size() || aw_log.size() != exp_aw.size()) begin
      n_fail++;
      $display("FAIL %s burst_count: got ar=%0d aw=%0d required ar=%0d aw=%0d",
               name, ar_log.size(), aw_log.size(), exp_ar.size(), exp_aw.size());
    end else begin
      for (int i = 0; i < exp_ar.size(); i++) begin
        n_cmp++;
        if (ar_log[i] !== exp_ar[i] || aw_log[i] !== exp_aw[i]) begin
          n_fail++;
          $display("FAIL %s burst%0d: got ar=%h aw=%h required ar=%h aw=%h",
                   name, i, ar_log[i], aw_log[i], exp_ar[i], exp_aw[i]);
        end
      end
    end
    n_cmp++;
    if (w_beats !== last_cnt) begin
      n_fail++; $display("FAIL %s w_beats: got %0d required %0d", name, w_beats, last_cnt);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i <= last_cnt; i++) begin
      if (mem[widx(last_dst + 32'(4 * i))] !== ref_mem[widx(last_dst + 32'(4 * i))]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s data: got %0d bad words (first at word %0d: %h) required 0 bad (%h)",
               name, bad, first_bad, mem[widx(last_dst + 32'(4 * first_bad))],
               ref_mem[widx(last_dst + 32'(4 * first_bad))]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; word_count = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({arvalid, awvalid, wvalid, rready, bready, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000", {arvalid, awvalid, wvalid, rready, bready, busy, done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({arvalid, awvalid, wvalid, rready, bready, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b required 0000000", {arvalid, awvalid, wvalid, rready, bready, busy, done});
    end
  endtask

  task automatic test_basic();
    bp = 0;
    launch(32'h400, 32'h800, 16);
    finish_copy("basic");
  endtask

  task automatic test_odd_length();
    bp = 0;
    launch(32'h400, 32'h800, 11);
    finish_copy("odd");
    n_cmp++;
    if (aw_log.size() != 2 || aw_log[0][39:32] !== 8'd7 || aw_log[1][39:32] !== 8'd2) begin
      n_fail++; $display("FAIL odd_awlen: got %0d bursts required awlen 7 then 2", aw_log.size());
    end
  endtask

  task automatic test_4k_cross();
    bp = 0;
    launch(32'hFF8, 32'h2000, 8);
    finish_copy("cross4k");
    n_cmp++;
    if (ar_log.size() != 2 || ar_log[0] !== {8'd1, 32'h0000_0FF8} || ar_log[1] !== {8'd5, 32'h0000_1000}) begin
      n_fail++; $display("FAIL cross4k_ar: got %0d bursts required len1@FF8 then len5@1000", ar_log.size());
    end
  endtask

  task automatic test_zero_count();
    bp = 0;
    launch(32'h40, 32'h9000, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_done_cycle2: got done=%b busy=%b required 1/0", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL zero_done_width: got %b required 0", done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (any_valid !== 1'b0 || ar_log.size() != 0 || aw_log.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_traffic: got valid_seen=%b ar=%0d aw=%0d done=%0d required 0/0/0/1",
               any_valid, ar_log.size(), aw_log.size(), done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bp = 0;
    launch(32'h1000, 32'h9000, 16);
    repeat (4) @(negedge clk);
    src_addr = 32'h3000; dst_addr = 32'hA000; word_count = CW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_copy("busy_start");
  endtask

  task automatic test_backpressure();
    bp = 1;
    for (int it = 0; it < 6; it++) begin
      launch(32'($urandom_range(0, 32'h6FFF)),
             32'h8000 + 32'($urandom_range(0, 32'h6FFF)),
             int'($urandom_range(1, 40)));
      finish_copy("backpressure");
    end
    bp = 0;
  endtask

  task automatic test_mid_reset();
    int k;
    bp = 0;
    launch(32'h2000, 32'hC000, 16);
    for (k = 0; k < 200 && wvalid !== 1'b1; k++) @(negedge clk);
    n_cmp++;
    if (wvalid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_wait: got wvalid=%b required 1 before reset", wvalid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({arvalid, awvalid, wvalid, rready, bready, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b required 0000000", {arvalid, awvalid, wvalid, rready, bready, busy, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL midreset_done: got %0d pulses required 0", done_cnt);
    end
    launch(32'h3004, 32'hD000, 4);
    finish_copy("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_4k_cross();
    test_zero_count();
    test_start_while_busy();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_block_copy.md
Name: axi_block_copy

Overview:
- AXI master DMA engine that copies a block of 32-bit words from a source byte address to a destination byte address.
- Copies in chunks: one read burst into an internal buffer, then one write burst from that buffer. Read and write bursts never overlap.
- Sits beside the cores as a second initiator on the system AXI bus. Primary use: memory-to-memory copies (framebuffer clears/blits, loader relocation) against the internal SRAM and the external memory controllers.

Parameters:
- BURST_LEN, 8, maximum beats per burst and depth of the internal buffer; power of two, 1..256.
- COUNT_WIDTH, 16, width of the word_count request field.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- axi_bus  interface  -  axi_interface, master side. Drives awaddr, awlen, awvalid, wdata, wvalid, bready, araddr, arlen, arvalid, rready; samples awready, wready, bvalid, arready, rvalid, rdata.
- start  input  1  one-cycle request pulse; sampled only in IDLE
- src_addr  input  32  source byte address; bits [1:0] ignored
- dst_addr  input  32  destination byte address; bits [1:0] ignored
- word_count  input  COUNT_WIDTH  number of 32-bit words to copy
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- Reset values: arvalid, awvalid, wvalid, rready, bready, busy and done are all 0; state is IDLE; internal counters are 0.
- Reset mid-transfer: aborts immediately. Outputs take their reset values, no done pulse is issued, and partial destination data is left as written.
- Start latching: on start in IDLE, latch src, dst and remaining = word_count. start is ignored while busy.
- Zero-length copy: word_count == 0 goes to DONE with no bus traffic. done pulses 2 cycles after start.
- Chunk size, computed at READ_ADDR entry: chunk = min(remaining, BURST_LEN, words to the next 4 KB boundary of src, words to the next 4 KB boundary of dst). No burst may cross a 4 KB boundary. chunk is always >= 1. arlen = awlen = chunk-1, zero-extended to 8 bits.
- States:
  - IDLE: busy=0. On start, go to READ_ADDR, or to DONE if word_count is 0.
  - READ_ADDR: arvalid=1, araddr={src[31:2],2'b00}. araddr and arlen stay stable until arready. On arready, go to READ_DATA with beat=0.
  - READ_DATA: rready=1. On rvalid, buffer[beat]=rdata and beat++. After beat chunk-1 is accepted, go to WRITE_ADDR.
  - WRITE_ADDR: awvalid=1, awaddr={dst[31:2],2'b00}, held stable until awready. On awready, go to WRITE_DATA with beat=0. wvalid is never asserted before the AW handshake; the internal SRAM slave depends on this.
  - WRITE_DATA: wvalid=1, wdata=buffer[beat]. Advance on wready. After the last beat, go to WRITE_RESP.
  - WRITE_RESP: bready=1. On bvalid: src+=4*chunk, dst+=4*chunk, remaining-=chunk. Go to DONE if remaining==0, else READ_ADDR.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Cycle-level timing:
  - arvalid rises 1 cycle after an accepted start.
  - Extra rvalid beats while rready=0 are impossible by protocol and need not be handled.
  - Addresses wrap modulo 2^32 with no error.
- Flop placement: buffer is a flop array with BURST_LEN entries, written only in READ_DATA. All control outputs are registered-state decodes, with no combinational path from AXI inputs to valid signals.

Decomposition:
- Shared package (defines.sv): state enum (STATE_IDLE, STATE_READ_ADDR, STATE_READ_DATA, STATE_WRITE_ADDR, STATE_WRITE_DATA, STATE_WRITE_RESP, STATE_DONE) and the AXI_4K_WORDS = 1024 constant.
- One natural sub-module, axi_copy_chunk_calc: purely combinational min-of-four chunk computation, reusable by future DMA blocks.
- The buffer stays inline.

Test Plan:
- Basic copy: preload SRAM words 0x100..0x10F with distinct data; start with src=0x400, dst=0x800, count=16, BURST_LEN=8. Require exactly 2 AR bursts (arlen=7), 2 AW bursts (awlen=7), dst words 0x200..0x20F matching the source, and one done pulse.
- Odd length: count=11. Require bursts with awlen 7 then 2, and 11 words written with no extra beats.
- 4 KB crossing: src=0xFF8, dst=0x2000, count=8. Require a first read burst of arlen=1 at 0xFF8 and a second of arlen=5 at 0x1000. The write bursts follow the same split; data must be correct.
- Zero count and start-while-busy: count=0 gives done 2 cycles after start and no valid signals asserted. A second start pulse during a 16-word copy is ignored; exactly one done pulse.
- Backpressure: slave randomly deasserts arready/awready/wready/bready (rvalid gaps). Require araddr/awaddr/wdata stable while valid && !ready, and the data still correct.
- Mid-transfer reset: assert reset during WRITE_DATA. Require all valids low asynchronously and busy=0. A new count=4 copy afterwards completes correctly.
